// File: rtl/regfile_sb_if.sv
// Bus between issue/writeback logic and the register file.
// Master drives reads, issue, writeback and flush. Slave returns read data, busy bits and init status.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic                init_done;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                flush;

    modport master (
        input  init_done, rd_data, rd_busy,
        output rd_en, rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data, flush
    );

    modport slave (
        output init_done, rd_data, rd_busy,
        input  rd_en, rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data, flush
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with a busy scoreboard for RAW stalls and a zeroing sweep after reset.
// Reads are combinational with same-cycle writeback bypass; x0 is hardwired to zero and never busy.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    logic [AW-1:0]       cnt;
    logic [NREGS-1:0]    busy;
    logic                init_done_q;
    logic [XLEN-1:0]     regs [NREGS];

    logic                wb_hit;
    logic                iss_hit;
    logic [NRD*XLEN-1:0] rd_data_c;
    logic [NRD-1:0]      rd_busy_c;
    logic [AW-1:0]       addr;

    assign wb_hit  = bus.wb_en && (bus.wb_addr != '0);
    assign iss_hit = bus.iss_en && (bus.iss_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            cnt         <= '0;
            busy        <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    busy[cnt] <= 1'b0;
                    if (cnt == AW'(NREGS - 1)) begin
                        state       <= RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                RUN: begin
                    // Flush wins over a concurrent issue; issue wins over a same-address writeback.
                    if (bus.flush) begin
                        busy <= '0;
                    end else begin
                        if (wb_hit)  busy[bus.wb_addr]  <= 1'b0;
                        if (iss_hit) busy[bus.iss_addr] <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT)
                regs[cnt] <= '0;
            else if (wb_hit)
                regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        addr      = '0;
        for (int i = 0; i < NRD; i++) begin
            addr = bus.rd_addr[i*AW +: AW];
            if (rst || state != RUN || !bus.rd_en[i] || addr == '0) begin
                rd_data_c[i*XLEN +: XLEN] = '0;
                rd_busy_c[i]              = 1'b0;
            end else if (bus.wb_en && bus.wb_addr == addr) begin
                rd_data_c[i*XLEN +: XLEN] = bus.wb_data;
                rd_busy_c[i]              = 1'b0;
            end else begin
                rd_data_c[i*XLEN +: XLEN] = regs[addr];
                rd_busy_c[i]              = busy[addr];
            end
        end
    end

    assign bus.rd_data   = rd_data_c;
    assign bus.rd_busy   = rd_busy_c;
    assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed scenarios plus random traffic against a behavioural model,
// and a second instance with 16 registers, 3 read ports and 64-bit data.
module tb_regfile_sb;
    localparam int XLEN  = 32, NREGS  = 32, AW  = 5, NRD  = 2;
    localparam int XLEN1 = 64, NREGS1 = 16, AW1 = 4, NRD1 = 3;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN),  .AW(AW),  .NRD(NRD))  bus0 ();
    regfile_sb_if #(.XLEN(XLEN1), .AW(AW1), .NRD(NRD1)) bus1 ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD))
        u0 (.clk(clk), .rst(rst), .bus(bus0));
    regfile_sb #(.XLEN(XLEN1), .NREGS(NREGS1), .AW(AW1), .NRD(NRD1))
        u1 (.clk(clk), .rst(rst1), .bus(bus1));

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural models: sweep progress counted in cycles, register contents as plain arrays.
    bit              m_run = 0;
    int              m_sweep = 0;
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    bit              m1_run = 0;
    int              m1_sweep = 0;
    logic [XLEN1-1:0] m1_regs [NREGS1];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [XLEN-1:0] expData(input int p);
        int a;
        a = int'(bus0.rd_addr[p*AW +: AW]);
        if (rst || !m_run || !bus0.rd_en[p] || a == 0) return '0;
        if (bus0.wb_en && int'(bus0.wb_addr) == a) return bus0.wb_data;
        return m_regs[a];
    endfunction

    function automatic bit expBusy(input int p);
        int a;
        a = int'(bus0.rd_addr[p*AW +: AW]);
        if (rst || !m_run || !bus0.rd_en[p] || a == 0) return 1'b0;
        if (bus0.wb_en && int'(bus0.wb_addr) == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic checkAll(input string tag);
        checkOutput($sformatf("%s_init_done", tag), 64'(bus0.init_done), 64'(m_run));
        for (int p = 0; p < NRD; p++) begin
            checkOutput($sformatf("%s_data%0d", tag, p), 64'(bus0.rd_data[p*XLEN +: XLEN]), 64'(expData(p)));
            checkOutput($sformatf("%s_busy%0d", tag, p), 64'(bus0.rd_busy[p]), 64'(expBusy(p)));
        end
    endtask

    task automatic applyStimulus(input logic [1:0] en, input int a0, input int a1,
                                 input bit iss, input int ia, input bit wb, input int wa,
                                 input logic [XLEN-1:0] wd, input bit fl);
        bus0.rd_en    = en;
        bus0.rd_addr  = {AW'(a1), AW'(a0)};
        bus0.iss_en   = iss;
        bus0.iss_addr = AW'(ia);
        bus0.wb_en    = wb;
        bus0.wb_addr  = AW'(wa);
        bus0.wb_data  = wd;
        bus0.flush    = fl;
        #1;
    endtask

    // Advance the models by the inputs present at the coming edge, then step past that edge.
    task automatic tick();
        if (rst) begin
            m_run = 0;
            m_sweep = 0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else if (!m_run) begin
            m_regs[m_sweep] = '0;
            m_busy[m_sweep] = 1'b0;
            m_sweep++;
            if (m_sweep == NREGS) m_run = 1;
        end else begin
            if (bus0.wb_en && bus0.wb_addr != 0) m_regs[bus0.wb_addr] = bus0.wb_data;
            if (bus0.flush) begin
                foreach (m_busy[i]) m_busy[i] = 1'b0;
            end else begin
                if (bus0.wb_en && bus0.wb_addr != 0)   m_busy[bus0.wb_addr] = 1'b0;
                if (bus0.iss_en && bus0.iss_addr != 0) m_busy[bus0.iss_addr] = 1'b1;
            end
        end
        if (rst1) begin
            m1_run = 0;
            m1_sweep = 0;
        end else if (!m1_run) begin
            m1_regs[m1_sweep] = '0;
            m1_sweep++;
            if (m1_sweep == NREGS1) m1_run = 1;
        end else if (bus1.wb_en && bus1.wb_addr != 0) begin
            m1_regs[bus1.wb_addr] = bus1.wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1, a2;
        logic [XLEN1-1:0] e;
        bus1.rd_en = '0; bus1.rd_addr = '0; bus1.iss_en = 0; bus1.iss_addr = '0;
        bus1.wb_en = 0;  bus1.wb_addr = '0; bus1.wb_data = '0; bus1.flush = 0;
        applyStimulus(2'b11, 5, 5, 0, 0, 0, 0, '0, 0);

        $display("[TB] reset and sweep");
        for (int k = 0; k < 3; k++) begin
            tick();
            checkAll("reset");
        end
        rst = 0;
        for (int k = 0; k < NREGS; k++) begin
            applyStimulus(2'b11, 5, k, 1, 5, 1, 5, 32'hDEADBEEF, 0);
            checkAll("sweep");
            checkOutput("sweep_x5_zero", 64'(bus0.rd_data[0 +: XLEN]), 64'h0);
            checkOutput("sweep_not_done", 64'(bus0.init_done), 64'h0);
            tick();
        end
        checkOutput("init_done_rise", 64'(bus0.init_done), 64'h1);

        $display("[TB] write, read and bypass");
        applyStimulus(2'b11, 7, 7, 0, 0, 1, 7, 32'h12345678, 0);
        checkAll("bypass");
        checkOutput("bypass_x7", 64'(bus0.rd_data[0 +: XLEN]), 64'h12345678);
        tick();
        applyStimulus(2'b01, 7, 0, 0, 0, 0, 0, '0, 0);
        checkOutput("array_x7", 64'(bus0.rd_data[0 +: XLEN]), 64'h12345678);
        applyStimulus(2'b11, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0);
        checkOutput("x0_bypass", 64'(bus0.rd_data[0 +: XLEN]), 64'h0);
        tick();
        applyStimulus(2'b11, 0, 7, 0, 0, 0, 0, '0, 0);
        checkOutput("x0_array", 64'(bus0.rd_data[0 +: XLEN]), 64'h0);
        checkAll("x0");

        $display("[TB] scoreboard");
        applyStimulus(2'b11, 3, 3, 1, 3, 0, 0, '0, 0);
        checkOutput("iss_t_busy", 64'(bus0.rd_busy[0]), 64'h0);
        tick();
        applyStimulus(2'b11, 3, 3, 0, 0, 0, 0, '0, 0);
        checkOutput("iss_t1_busy", 64'(bus0.rd_busy[1]), 64'h1);
        tick(); tick(); tick();
        applyStimulus(2'b11, 3, 3, 0, 0, 1, 3, 32'h00000055, 0);
        checkOutput("wb_t4_busy", 64'(bus0.rd_busy[0]), 64'h0);
        checkOutput("wb_t4_data", 64'(bus0.rd_data[0 +: XLEN]), 64'h55);
        tick();
        applyStimulus(2'b11, 3, 3, 0, 0, 0, 0, '0, 0);
        checkOutput("wb_t5_busy", 64'(bus0.rd_busy[0]), 64'h0);

        $display("[TB] simultaneous events");
        applyStimulus(2'b11, 9, 4, 1, 9, 1, 9, 32'h99999999, 0);
        checkAll("iss_wb_same");
        tick();
        applyStimulus(2'b11, 9, 4, 1, 4, 0, 0, '0, 1);
        checkOutput("iss_wb_data", 64'(bus0.rd_data[0 +: XLEN]), 64'h99999999);
        checkOutput("iss_wb_busy", 64'(bus0.rd_busy[0]), 64'h1);
        tick();
        applyStimulus(2'b11, 9, 4, 0, 0, 0, 0, '0, 0);
        checkOutput("flush_x4_busy", 64'(bus0.rd_busy[1]), 64'h0);
        checkOutput("flush_x9_busy", 64'(bus0.rd_busy[0]), 64'h0);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus(2'($urandom), int'($urandom_range(0, NREGS-1)), int'($urandom_range(0, NREGS-1)),
                          1'($urandom), int'($urandom_range(0, NREGS-1)),
                          1'($urandom), int'($urandom_range(0, NREGS-1)),
                          $urandom, ($urandom_range(0, 15) == 0));
            checkAll("random");
            tick();
        end

        $display("[TB] mid-operation reset");
        applyStimulus(2'b00, 0, 0, 1, 6, 1, 2, 32'hA5A5A5A5, 0);
        tick();
        applyStimulus(2'b11, 2, 6, 0, 0, 0, 0, '0, 0);
        checkOutput("pre_x2", 64'(bus0.rd_data[0 +: XLEN]), 64'hA5A5A5A5);
        checkOutput("pre_x6_busy", 64'(bus0.rd_busy[1]), 64'h1);
        rst = 1; tick(); rst = 0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1;
        checkAll("mid_rst");
        tick(); rst = 0;
        for (int k = 0; k < NREGS; k++) begin
            checkOutput("resweep_not_done", 64'(bus0.init_done), 64'h0);
            tick();
        end
        checkOutput("resweep_done", 64'(bus0.init_done), 64'h1);
        checkOutput("post_x2_zero", 64'(bus0.rd_data[0 +: XLEN]), 64'h0);
        checkOutput("post_x6_busy", 64'(bus0.rd_busy[1]), 64'h0);
        checkAll("post_rst");

        $display("[TB] 16-register, 3-port, 64-bit instance");
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, '0, 0);
        tick(); rst1 = 0;
        for (int k = 0; k < NREGS1; k++) begin
            checkOutput("p1_sweep_not_done", 64'(bus1.init_done), 64'h0);
            tick();
        end
        checkOutput("p1_sweep_done", 64'(bus1.init_done), 64'h1);
        for (int r = 1; r < NREGS1; r++) begin
            bus1.wb_en = 1; bus1.wb_addr = AW1'(r); bus1.wb_data = {$urandom, $urandom};
            tick();
        end
        bus1.wb_en = 0;
        bus1.rd_en = 3'b111;
        for (int k = 0; k < 12; k++) begin
            a0 = int'($urandom_range(0, NREGS1-1));
            a1 = (a0 + 5) % NREGS1;
            a2 = (a0 + 11) % NREGS1;
            bus1.rd_addr = {AW1'(a2), AW1'(a1), AW1'(a0)};
            #1;
            e = (a0 == 0) ? '0 : m1_regs[a0];
            checkOutput("p1_port0", bus1.rd_data[0 +: XLEN1], e);
            e = (a1 == 0) ? '0 : m1_regs[a1];
            checkOutput("p1_port1", bus1.rd_data[XLEN1 +: XLEN1], e);
            e = (a2 == 0) ? '0 : m1_regs[a2];
            checkOutput("p1_port2", bus1.rd_data[2*XLEN1 +: XLEN1], e);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
